// File: rtl/ps2_mouse_init.sv
// ps2_mouse_init: host-to-device PS/2 command sender with line ACK check,
// 0xFA response wait, per-phase watchdog and bounded retries.
module ps2_mouse_init #(
    parameter logic [7:0] CMD = 8'hF4,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_enable,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] attempts
);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, TX, ACK, RESP, DONE, FAIL} state_t;
    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);
    state_t state, state_n;
    logic [1:0] clk_s, data_s;
    logic clk_prev, fall, active, wd_on, failed, dr, dr_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [2:0] att, att_n;
    logic [31:0] cnt;
    assign fall = clk_prev & ~clk_s[1];
    assign active = state inside {INHIBIT, REQ, TX, ACK, RESP};
    assign wd_on = state inside {REQ, TX, ACK, RESP};
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            clk_s <= 2'b11;
            data_s <= 2'b11;
            clk_prev <= 1'b1;
            dr <= 1'b0;
            bit_cnt <= '0;
            att <= '0;
            cnt <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk_in};
            data_s <= {data_s[0], ps2_data_in};
            clk_prev <= clk_s[1];
            state <= state_n;
            dr <= dr_n;
            bit_cnt <= bit_cnt_n;
            att <= att_n;
            cnt <= (state_n != state || !active || (fall && wd_on)) ? '0 : cnt + 32'd1;
        end
    end
    // The REQ-phase falling edge already carries bit 0, so the ACK lands on the 11th edge.
    always_comb begin
        state_n = state;
        dr_n = dr;
        bit_cnt_n = bit_cnt;
        att_n = att;
        failed = 1'b0;
        case (state)
            IDLE, DONE, FAIL: if (start) begin
                state_n = INHIBIT;
                att_n = 3'd1;
                bit_cnt_n = '0;
            end
            INHIBIT: if (cnt == INH_LAST) begin
                state_n = REQ;
                dr_n = 1'b1;
            end
            REQ, TX: if (fall) begin
                dr_n = bit_cnt == 4'd9 ? 1'b0 : bit_cnt == 4'd8 ? ^CMD : ~CMD[bit_cnt[2:0]];
                bit_cnt_n = bit_cnt + 4'd1;
                state_n = bit_cnt == 4'd9 ? ACK : TX;
            end
            ACK: if (fall) begin
                failed = data_s[1];
                state_n = RESP;
            end
            RESP: if (rx_valid) begin
                failed = rx_byte != 8'hFA;
                state_n = DONE;
            end
            default: ;
        endcase
        if (wd_on && cnt == WD_LAST) failed = 1'b1;
        if (failed) begin
            dr_n = 1'b0;
            bit_cnt_n = '0;
            state_n = att <= RETRY_MAX ? INHIBIT : FAIL;
            att_n = att <= RETRY_MAX ? att + 3'd1 : att;
        end
    end
    assign ps2_clk_oe = state == INHIBIT;
    assign ps2_data_oe = dr | (ps2_clk_oe && cnt == INH_LAST);
    assign rx_enable = !(state inside {INHIBIT, REQ, TX, ACK});
    assign busy = active;
    assign done = state == DONE;
    assign error = state == FAIL;
    // Attempt counts beyond 3 read as 3 on the 2-bit port.
    assign attempts = att[2] ? 2'd3 : att[1:0];
endmodule

// File: tb/tb_ps2_mouse_init.sv
// tb_ps2_mouse_init: directed bench with a bit-level PS/2 device model driving
// the open-drain lines and a scripted receiver response.
module tb_ps2_mouse_init;
    localparam int INH = 20;
    localparam int TO = 200;
    localparam int H = 20;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, rx_enable, busy, done, error;
    logic [1:0] attempts;
    logic [9:0] got;
    logic prev_coe = 1'b0;
    int checks = 0, passes = 0;
    int inh_cyc = 0, inh_both = 0, inh_phases = 0;

    ps2_mouse_init #(.CMD(8'hF4), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_enable(rx_enable),
        .busy(busy), .done(done), .error(error), .attempts(attempts)
    );

    always #5 clk = ~clk;
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always @(negedge clk) begin
        if (ps2_clk_oe) inh_cyc++;
        if (ps2_clk_oe && ps2_data_oe) inh_both++;
        if (ps2_clk_oe && !prev_coe) inh_phases++;
        prev_coe = ps2_clk_oe;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic dev(input int nbits, input logic nack, input logic resp_en, input logic [7:0] resp);
        int t;
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
            cyc(1);
            t++;
        end
        checks++; if (t >= 2000) $display("FAIL dev_req no host request within %0d cycles", t); else passes++;
        if (t >= 2000) return;
        cyc(5);
        for (int i = 0; i < nbits && i < 10; i++) begin
            dev_clk = 1'b0;
            cyc(H);
            dev_clk = 1'b1;
            got[i] = ps2_data_in;
            cyc(H);
        end
        if (nbits < 10) return;
        dev_data = nack;
        dev_clk = 1'b0;
        cyc(H);
        dev_clk = 1'b1;
        cyc(2);
        dev_data = 1'b1;
        cyc(H);
        if (resp_en) begin
            rx_byte = resp;
            rx_valid = 1'b1;
            cyc(1);
            rx_valid = 1'b0;
        end
        cyc(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL rst_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); else passes++;
        checks++; if ({rx_enable, done, error} !== 3'b100) $display("FAIL rst_flags got %b want 100", {rx_enable, done, error}); else passes++;
        checks++; if (attempts !== 2'd0) $display("FAIL rst_attempts got %0d want 0", attempts); else passes++;
        reset = 1'b1;
        start = 1'b1;
        cyc(1);
        reset = 1'b0;
        start = 1'b0;
        cyc(1);
        checks++; if (busy !== 1'b0) $display("FAIL rst_start_busy got %b want 0", busy); else passes++;
    endtask

    task automatic test_nominal();
        int b, bb;
        b = inh_cyc;
        bb = inh_both;
        pulse_start();
        checks++; if ({busy, rx_enable, attempts} !== 4'b1001) $display("FAIL nom_begin got %b want 1001", {busy, rx_enable, attempts}); else passes++;
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if (got !== 10'b10_1111_0100) $display("FAIL nom_bits got %b want 1011110100", got); else passes++;
        checks++; if ({done, error, busy} !== 3'b100) $display("FAIL nom_flags got %b want 100", {done, error, busy}); else passes++;
        checks++; if (attempts !== 2'd1) $display("FAIL nom_attempts got %0d want 1", attempts); else passes++;
        checks++; if (inh_cyc - b !== INH) $display("FAIL nom_inhibit got %0d want %0d", inh_cyc - b, INH); else passes++;
        checks++; if (inh_both - bb !== 1) $display("FAIL nom_start_bit got %0d want 1", inh_both - bb); else passes++;
        checks++; if ({ps2_clk_oe, ps2_data_oe, rx_enable} !== 3'b001) $display("FAIL nom_lines got %b want 001", {ps2_clk_oe, ps2_data_oe, rx_enable}); else passes++;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if ({done, busy, attempts} !== 4'b0101) $display("FAIL b2b_restart got %b want 0101", {done, busy, attempts}); else passes++;
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if ({done, attempts} !== 3'b101) $display("FAIL b2b_done got %b want 101", {done, attempts}); else passes++;
    endtask

    task automatic test_nack();
        int p;
        p = inh_phases;
        pulse_start();
        dev(10, 1'b1, 1'b0, 8'h00);
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if (inh_phases - p !== 2) $display("FAIL nack_phases got %0d want 2", inh_phases - p); else passes++;
        checks++; if ({done, error, attempts} !== 4'b1010) $display("FAIL nack_done got %b want 1010", {done, error, attempts}); else passes++;
    endtask

    task automatic test_resend();
        int p;
        p = inh_phases;
        pulse_start();
        repeat (3) dev(10, 1'b0, 1'b1, 8'hFE);
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if (inh_phases - p !== 4) $display("FAIL resend_phases got %0d want 4", inh_phases - p); else passes++;
        checks++; if ({done, error, attempts} !== 4'b1011) $display("FAIL resend_done got %b want 1011", {done, error, attempts}); else passes++;
    endtask

    task automatic test_dead_bus();
        int p, t;
        p = inh_phases;
        pulse_start();
        t = 0;
        while (!error && t < 3000) begin
            cyc(1);
            t++;
        end
        checks++; if (error !== 1'b1) $display("FAIL dead_error got %b want 1", error); else passes++;
        checks++; if (t < 875 || t > 885) $display("FAIL dead_latency got %0d want about %0d", t, 4 * (INH + TO)); else passes++;
        checks++; if ({busy, done, ps2_clk_oe, ps2_data_oe} !== 4'b0000) $display("FAIL dead_lines got %b want 0000", {busy, done, ps2_clk_oe, ps2_data_oe}); else passes++;
        checks++; if (inh_phases - p !== 4) $display("FAIL dead_phases got %0d want 4", inh_phases - p); else passes++;
    endtask

    task automatic test_reset_mid_tx();
        pulse_start();
        dev(5, 1'b0, 1'b0, 8'h00);
        checks++; if ({busy, rx_enable} !== 2'b10) $display("FAIL midtx_pre got %b want 10", {busy, rx_enable}); else passes++;
        reset = 1'b1;
        cyc(1);
        checks++; if ({ps2_clk_oe, ps2_data_oe, busy, attempts} !== 5'b00000) $display("FAIL midtx_reset got %b want 00000", {ps2_clk_oe, ps2_data_oe, busy, attempts}); else passes++;
        reset = 1'b0;
        cyc(2);
        pulse_start();
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if (got !== 10'b10_1111_0100) $display("FAIL midtx_bits got %b want 1011110100", got); else passes++;
        checks++; if ({done, attempts} !== 3'b101) $display("FAIL midtx_done got %b want 101", {done, attempts}); else passes++;
    endtask

    task automatic test_stray();
        int b, p;
        b = inh_cyc;
        p = inh_phases;
        pulse_start();
        cyc(3);
        rx_byte = 8'hFA;
        rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        checks++; if ({done, ps2_clk_oe} !== 2'b01) $display("FAIL stray_rx got %b want 01", {done, ps2_clk_oe}); else passes++;
        pulse_start();
        checks++; if ({ps2_clk_oe, attempts} !== 3'b101) $display("FAIL stray_start got %b want 101", {ps2_clk_oe, attempts}); else passes++;
        dev(10, 1'b0, 1'b1, 8'hFA);
        checks++; if ({done, attempts} !== 3'b101) $display("FAIL stray_done got %b want 101", {done, attempts}); else passes++;
        checks++; if (inh_cyc - b !== INH || inh_phases - p !== 1) $display("FAIL stray_inhibit got %0d/%0d want %0d/1", inh_cyc - b, inh_phases - p, INH); else passes++;
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_nack();
        test_resend();
        test_dead_bus();
        test_reset_mid_tx();
        test_stray();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
